ram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one single-port RAM (synchronous write, asynchronous read) between requesters A and B. Each requester raises a request with address, write flag and write data. The arbiter grants exactly one access per cycle, drives the RAM port, and returns registered read data with a valid pulse. It sits between the RAM and its two clients, and is the only block allowed to drive the RAM's address, data-in and write-enable.

---
 rtl/ram_port_arbiter_if.sv | 49 ++++
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter_if
// Bundles every signal between the arbiter, its two requesters (A and B) and
// the single-port RAM it owns.
//   Requester side (per x in {a,b}):
//     req_x, wr_x, addr_x, wdata_x   request, write flag, address, write data
//     gnt_x                          high for exactly the grant cycle
//     rdata_x, rvalid_x              registered read data, one-cycle valid
//     cnt_x                          granted-transaction counter (wrapping)
//   RAM side:
//     ram_addr, ram_din, ram_we      driven only by the arbiter
//     ram_dout                       asynchronous RAM read data
//   Status:
//     busy                           high while a grant is in progress
// Modports: slave = arbiter, master = requesters plus RAM environment.
// ----------------------------------------------------------------------------
interface ram_port_arbiter_if #(
    parameter int DW = 8,
    parameter int m  = 2,
    parameter int CW = 8
);
    logic          req_a,    req_b;
    logic          wr_a,     wr_b;
    logic [m-1:0]  addr_a,   addr_b;
    logic [DW-1:0] wdata_a,  wdata_b;
    logic          gnt_a,    gnt_b;
    logic [DW-1:0] rdata_a,  rdata_b;
    logic          rvalid_a, rvalid_b;
    logic [CW-1:0] cnt_a,    cnt_b;
    logic [m-1:0]  ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          busy;

    modport slave (
        input  req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
        input  ram_dout,
        output gnt_a, gnt_b, rdata_a, rdata_b, rvalid_a, rvalid_b,
        output cnt_a, cnt_b, ram_addr, ram_din, ram_we, busy
    );

    modport master (
        output req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
        output ram_dout,
        input  gnt_a, gnt_b, rdata_a, rdata_b, rvalid_a, rvalid_b,
        input  cnt_a, cnt_b, ram_addr, ram_din, ram_we, busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
// Round-robin arbiter sharing one single-port RAM (synchronous write,
// asynchronous read) between requesters A and B. One access is granted per
// cycle; read data comes back registered one cycle after the grant.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   ram_port_arbiter_if.slave (requests, grants, RAM port, counters)
// ----------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int DW = 8,
    parameter int m  = 2,
    parameter int CW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    ram_port_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;        // 0: A served last, 1: B served last
    logic          elig_a, elig_b;
    logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic          rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic          rd_done_a, rd_done_b;

    logic          gnt_a, gnt_b, we_mux;
    logic [m-1:0]  addr_mux;
    logic [DW-1:0] din_mux;

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the read-data registers are reset along with the control state
    // because their reset value is observable on the ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // A requester in its own grant cycle is masked, which is what lets the
    // other side in on the very next cycle.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        elig_a  = bus.req_a && (state_q != GNT_A);
        elig_b  = bus.req_b && (state_q != GNT_B);
        state_d = IDLE;
        last_d  = last_q;
        if (elig_a && elig_b) begin
            state_d = last_q ? GNT_A : GNT_B;
        end else if (elig_a) begin
            state_d = GNT_A;
        end else if (elig_b) begin
            state_d = GNT_B;
        end
        if (state_d == GNT_A) begin
            last_d = 1'b0;
        end else if (state_d == GNT_B) begin
            last_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode, from the state only. Reset forces IDLE asynchronously,
    // so ram_we drops at once and an in-flight write never lands.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        we_mux   = 1'b0;
        addr_mux = '0;
        din_mux  = '0;
        unique case (state_q)
            GNT_A: begin
                gnt_a    = 1'b1;
                we_mux   = bus.wr_a;
                addr_mux = bus.addr_a;
                din_mux  = bus.wdata_a;
            end
            GNT_B: begin
                gnt_b    = 1'b1;
                we_mux   = bus.wr_b;
                addr_mux = bus.addr_b;
                din_mux  = bus.wdata_b;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and read return: captured at the edge that ends a grant.
    // ------------------------------------------------------------------
    always_comb begin
        rd_done_a  = (state_q == GNT_A) && !bus.wr_a;
        rd_done_b  = (state_q == GNT_B) && !bus.wr_b;
        cnt_a_d    = (state_q == GNT_A) ? cnt_a_q + CW'(1) : cnt_a_q;
        cnt_b_d    = (state_q == GNT_B) ? cnt_b_q + CW'(1) : cnt_b_q;
        rdata_a_d  = rd_done_a ? bus.ram_dout : rdata_a_q;
        rdata_b_d  = rd_done_b ? bus.ram_dout : rdata_b_q;
        rvalid_a_d = rd_done_a;
        rvalid_b_d = rd_done_b;
    end

    assign bus.gnt_a    = gnt_a;
    assign bus.gnt_b    = gnt_b;
    assign bus.ram_we   = we_mux;
    assign bus.ram_addr = addr_mux;
    assign bus.ram_din  = din_mux;
    assign bus.busy     = (state_q != IDLE);
    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.cnt_a    = cnt_a_q;
    assign bus.cnt_b    = cnt_b_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter
// Self-checking bench for ram_port_arbiter: a 4-entry RAM environment, a
// directed vector table, hand-written corner sequences and a randomized run
// checked against a requester-level reference model.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge before the next drive.
// ----------------------------------------------------------------------------
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DW(DW), .m(AW), .CW(CW)) bus ();

    ram_port_arbiter #(.DW(DW), .m(AW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM environment: synchronous write, asynchronous read, with a preload
    // port used only while the arbiter is idle.
    logic [DW-1:0] mem [4];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    end
    assign bus.ram_dout = mem[bus.ram_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        bus.req_a = ra; bus.wr_a = wa; bus.addr_a = aa; bus.wdata_a = da;
        bus.req_b = rb; bus.wr_b = wb; bus.addr_b = ab; bus.wdata_b = db;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic ra, wa; logic [AW-1:0] aa; logic [DW-1:0] da;
        logic rb, wb; logic [AW-1:0] ab; logic [DW-1:0] db;
        logic ga, gb, bsy, we; logic [AW-1:0] addr; logic [DW-1:0] din;
        logic va, vb; logic [DW-1:0] rda, rdb; logic [CW-1:0] ca, cb;
    } vec_t;

    function automatic vec_t mk(
        input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
        input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
        input logic ga, input logic gb, input logic bsy, input logic we,
        input logic [AW-1:0] addr, input logic [DW-1:0] din,
        input logic va, input logic vb, input logic [DW-1:0] rda, input logic [DW-1:0] rdb,
        input logic [CW-1:0] ca, input logic [CW-1:0] cb);
        vec_t v;
        v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
        v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
        v.ga = ga; v.gb = gb; v.bsy = bsy; v.we = we; v.addr = addr; v.din = din;
        v.va = va; v.vb = vb; v.rda = rda; v.rdb = rdb; v.ca = ca; v.cb = cb;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Requesters indexed 0 (A) and 1 (B); cur is who holds the RAM this
    // cycle (-1 for nobody).
    logic          m_req [2];
    logic          m_wr  [2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wd  [2];
    logic [DW-1:0] mem_ref [4];
    int            cur, last_srv, ended;
    int            e_cnt [2];
    logic [DW-1:0] e_rd  [2];
    logic          e_rv  [2];

    task automatic model_reset();
        cur = -1; last_srv = 1; ended = -1;
        for (int k = 0; k < 2; k++) begin
            e_cnt[k] = 0; e_rd[k] = '0; e_rv[k] = 1'b0;
            m_req[k] = 1'b0; m_wr[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0;
        end
    endtask

    task automatic model_edge();
        int n;
        int cand;
        ended = cur;
        e_rv[0] = 1'b0;
        e_rv[1] = 1'b0;
        if (cur >= 0) begin
            e_cnt[cur] = (e_cnt[cur] + 1) % (1 << CW);
            if (m_wr[cur]) mem_ref[m_addr[cur]] = m_wd[cur];
            else begin
                e_rd[cur] = mem_ref[m_addr[cur]];
                e_rv[cur] = 1'b1;
            end
        end
        n = 0;
        cand = -1;
        for (int k = 0; k < 2; k++) begin
            if (m_req[k] && cur != k) begin
                cand = k;
                n++;
            end
        end
        if (n == 0) cur = -1;
        else if (n == 1) cur = cand;
        else cur = 1 - last_srv;
        if (cur >= 0) last_srv = cur;
    endtask

    task automatic model_drive();
        drive(m_req[0], m_wr[0], m_addr[0], m_wd[0], m_req[1], m_wr[1], m_addr[1], m_wd[1]);
    endtask

    task automatic new_op(input int k);
        m_wr[k]   = 1'($urandom_range(1, 0));
        m_addr[k] = 2'($urandom_range(3, 0));
        m_wd[k]   = 8'($urandom_range(255, 0));
    endtask

    task automatic model_compare();
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] dn;
        we = 1'b0; ad = '0; dn = '0;
        if (cur >= 0) begin
            we = m_wr[cur]; ad = m_addr[cur]; dn = m_wd[cur];
        end
        check("rnd_ctrl", 32'({bus.gnt_a, bus.gnt_b, bus.busy, bus.ram_we, bus.rvalid_a, bus.rvalid_b}),
              32'({cur == 0, cur == 1, cur >= 0, we, e_rv[0], e_rv[1]}));
        check("rnd_ram", 32'({bus.ram_addr, bus.ram_din}), 32'({ad, dn}));
        check("rnd_rdata", 32'({bus.rdata_a, bus.rdata_b}), 32'({e_rd[0], e_rd[1]}));
        check("rnd_cnt", 32'({bus.cnt_a, bus.cnt_b}), 32'({2'(e_cnt[0]), 2'(e_cnt[1])}));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t v[9];
        int   pulses;
        logic [5:0] pat;
        int   wrap_exp[5] = '{1, 2, 3, 0, 1};

        // Reset state
        do_reset();
        check("rst_ctrl", 32'({bus.gnt_a, bus.gnt_b, bus.busy, bus.ram_we, bus.rvalid_a, bus.rvalid_b}), 32'd0);
        check("rst_ram", 32'({bus.ram_addr, bus.ram_din}), 32'd0);
        check("rst_data", 32'({bus.rdata_a, bus.rdata_b, bus.cnt_a, bus.cnt_b}), 32'd0);

        // Single read of a preloaded word
        preload(2'd2, 8'h5A);
        drive(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        check("rd1_gnt", 32'({bus.gnt_a, bus.gnt_b, bus.busy, bus.ram_addr}), 32'({3'b101, 2'd2}));
        tick();
        drive_idle();
        check("rd1_data", 32'({bus.rvalid_a, bus.rdata_a, bus.cnt_a}), 32'({1'b1, 8'h5A, 2'd1}));
        check("rd1_gnt_off", 32'({bus.gnt_a, bus.busy}), 32'd0);

        // Vector table: simultaneous requests from reset, back-to-back
        // alternation, write then read of the same word, re-request, wrap.
        do_reset();
        preload(2'd0, 8'h10);
        preload(2'd1, 8'h21);
        preload(2'd2, 8'h5A);
        preload(2'd3, 8'h00);
        v[0] = mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd2, 8'h00,
                  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 2'd0);
        v[1] = mk(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd2, 8'h00,
                  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 2'd1, 2'd0);
        v[2] = mk(1'b1, 1'b1, 2'd3, 8'h77, 1'b1, 1'b0, 2'd2, 8'h00,
                  1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 8'h77, 1'b0, 1'b1, 8'h10, 8'h5A, 2'd1, 2'd1);
        v[3] = mk(1'b1, 1'b1, 2'd3, 8'h77, 1'b1, 1'b0, 2'd3, 8'h00,
                  1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0, 8'h10, 8'h5A, 2'd2, 2'd1);
        v[4] = mk(1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0, 2'd3, 8'h00,
                  1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b1, 8'h10, 8'h77, 2'd2, 2'd2);
        v[5] = mk(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h21, 8'h77, 2'd3, 2'd2);
        v[6] = mk(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00,
                  1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 8'h21, 8'h77, 2'd3, 2'd2);
        v[7] = mk(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h21, 8'h77, 2'd0, 2'd2);
        v[8] = mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h21, 8'h77, 2'd0, 2'd2);
        for (int i = 0; i < 9; i++) begin
            drive(v[i].ra, v[i].wa, v[i].aa, v[i].da, v[i].rb, v[i].wb, v[i].ab, v[i].db);
            tick();
            check($sformatf("vec%0d_ctrl", i),
                  32'({bus.gnt_a, bus.gnt_b, bus.busy, bus.ram_we, bus.rvalid_a, bus.rvalid_b}),
                  32'({v[i].ga, v[i].gb, v[i].bsy, v[i].we, v[i].va, v[i].vb}));
            check($sformatf("vec%0d_ram", i), 32'({bus.ram_addr, bus.ram_din}), 32'({v[i].addr, v[i].din}));
            check($sformatf("vec%0d_rdata", i), 32'({bus.rdata_a, bus.rdata_b}), 32'({v[i].rda, v[i].rdb}));
            check($sformatf("vec%0d_cnt", i), 32'({bus.cnt_a, bus.cnt_b}), 32'({v[i].ca, v[i].cb}));
        end

        // Lone requester holding req: served every other cycle
        do_reset();
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
        pat = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            pat = {pat[4:0], bus.gnt_a};
        end
        drive_idle();
        check("lone_pattern", 32'(pat), 32'(6'b101010));
        check("lone_cnt", 32'(bus.cnt_a), 32'd3);

        // Write by A, read of the same word by B one cycle later
        do_reset();
        pulses = 0;
        drive(1'b1, 1'b1, 2'd1, 8'hC3, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        pulses += int'(bus.rvalid_b);
        drive(1'b1, 1'b1, 2'd1, 8'hC3, 1'b1, 1'b0, 2'd1, 8'h00);
        tick();
        pulses += int'(bus.rvalid_b);
        check("haz_gnt_b", 32'({bus.gnt_a, bus.gnt_b}), 32'(2'b01));
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'h00);
        tick();
        pulses += int'(bus.rvalid_b);
        check("haz_rdata_b", 32'(bus.rdata_b), 32'h0000_00C3);
        drive_idle();
        for (int c = 0; c < 2; c++) begin
            tick();
            pulses += int'(bus.rvalid_b);
        end
        check("haz_rvalid_pulses", 32'(pulses), 32'd1);

        // Reset in the middle of a write grant (no reset beforehand, so the
        // priority pointer and read data must be restored by this reset)
        preload(2'd3, 8'h00);
        drive(1'b1, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        check("rstw_pre_we", 32'({bus.gnt_a, bus.ram_we}), 32'(2'b11));
        rst = 1'b1;
        drive_idle();
        #1;
        check("rstw_async", 32'({bus.gnt_a, bus.gnt_b, bus.busy, bus.ram_we, bus.ram_addr, bus.ram_din}), 32'd0);
        tick();
        rst = 1'b0;
        check("rstw_mem3", 32'(mem[3]), 32'd0);
        check("rstw_outs", 32'({bus.rdata_a, bus.rdata_b, bus.rvalid_a, bus.rvalid_b, bus.cnt_a, bus.cnt_b}), 32'd0);
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
        tick();
        check("rstw_tie_to_a", 32'({bus.gnt_a, bus.gnt_b}), 32'(2'b10));
        drive_idle();
        tick();
        tick();

        // Counter wrap with five grants to B
        do_reset();
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("wrap%0d_gnt", k), 32'({bus.gnt_a, bus.gnt_b}), 32'(2'b01));
            tick();
            check($sformatf("wrap%0d_cnt", k), 32'(bus.cnt_b), 32'(wrap_exp[k]));
        end
        drive_idle();

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int a = 0; a < 4; a++) begin
            logic [DW-1:0] d;
            d = 8'($urandom_range(255, 0));
            preload(2'(a), d);
            mem_ref[a] = d;
        end
        model_drive();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            model_compare();
            for (int k = 0; k < 2; k++) begin
                if (m_req[k]) begin
                    // Operands may only change once this requester's grant has ended.
                    if (ended == k) begin
                        if ($urandom_range(1, 0) == 0) m_req[k] = 1'b0;
                        else new_op(k);
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    m_req[k] = 1'b1;
                    new_op(k);
                end
            end
            model_drive();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
